// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store sequencer.
// Misaligned word-crossing accesses are split in two, and every memory access is guarded by a timeout.
module mem_access_ctrl #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_rdy,
   input  logic        req_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        resp_valid,
   input  logic        resp_rdy,
   output logic [31:0] resp_data,
   output logic        resp_err
);
   typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
   state_t      state;
   logic        st_store;
   logic [2:0]  st_f3;
   logic [1:0]  st_off;
   logic [3:0]  st_hi_be;
   logic [31:0] st_sd_hi, st_lo;
   logic [15:0] cnt;
   logic [3:0]  sz_mask;
   logic [7:0]  mask;
   logic [63:0] sd, both;
   logic [31:0] raw, ld_val;
   logic        legal;
   assign req_rdy = state == IDLE && !rst;
   always_comb begin
      sz_mask = req_funct3[1:0] == 2'd0 ? 4'h1 : req_funct3[1:0] == 2'd1 ? 4'h3 : 4'hF;
      mask = {4'h0, sz_mask} << req_addr[1:0];
      sd = {32'h0, req_wdata} << {req_addr[1:0], 3'b000};
      legal = req_funct3[1:0] != 2'd3 && !(req_funct3[2] && (req_store || req_funct3[1]));
      both = state == ACC1 ? {mem_rdata, st_lo} : {32'h0, mem_rdata};
      raw = 32'(both >> {st_off, 3'b000});
      ld_val = st_f3[1] ? raw :
               st_f3[0] ? {{16{raw[15] & !st_f3[2]}}, raw[15:0]} :
                          {{24{raw[7] & !st_f3[2]}}, raw[7:0]};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         mem_req <= 1'b0;
         mem_we <= 1'b0;
         mem_addr <= 32'h0;
         mem_wdata <= 32'h0;
         mem_be <= 4'h0;
         resp_valid <= 1'b0;
         resp_data <= 32'h0;
         resp_err <= 1'b0;
         cnt <= 16'h0;
         st_store <= 1'b0;
         st_f3 <= 3'h0;
         st_off <= 2'h0;
         st_hi_be <= 4'h0;
         st_sd_hi <= 32'h0;
         st_lo <= 32'h0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               st_store <= req_store;
               st_f3 <= req_funct3;
               st_off <= req_addr[1:0];
               st_hi_be <= mask[7:4];
               st_sd_hi <= sd[63:32];
               if (legal) begin
                  state <= ACC0;
                  mem_req <= 1'b1;
                  mem_we <= req_store;
                  mem_addr <= {req_addr[31:2], 2'b00};
                  mem_be <= mask[3:0];
                  mem_wdata <= sd[31:0];
               end else begin
                  state <= RESP;
                  resp_valid <= 1'b1;
                  resp_err <= 1'b1;
                  resp_data <= 32'h0;
               end
            end
            ACC0, ACC1: if (!mem_req) begin
               // mem_req is low here only in the idle cycle before the second half of a split
               mem_req <= 1'b1;
               mem_addr <= mem_addr + 32'd4;
               mem_be <= st_hi_be;
               mem_wdata <= st_sd_hi;
            end else if (mem_ack) begin
               mem_req <= 1'b0;
               cnt <= 16'h0;
               st_lo <= mem_rdata;
               if (state == ACC0 && st_hi_be != 4'h0) state <= ACC1;
               else begin
                  state <= RESP;
                  resp_valid <= 1'b1;
                  resp_err <= 1'b0;
                  resp_data <= st_store ? 32'h0 : ld_val;
               end
            end else if (cnt == 16'(TIMEOUT_CYCLES - 1)) begin
               mem_req <= 1'b0;
               cnt <= 16'h0;
               state <= RESP;
               resp_valid <= 1'b1;
               resp_err <= 1'b1;
               resp_data <= 32'h0;
            end else cnt <= cnt + 16'd1;
            RESP: if (resp_rdy) begin
               state <= IDLE;
               resp_valid <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequences data-memory accesses for loads and stores between the execute stage and the memory/assembly stages. It accepts one request at a time and drives a single-outstanding req/ack memory port. Word-crossing misaligned accesses are split into two aligned word accesses. Load data is merged and extended into a final register value; completion (or error) is reported through a valid/ready response port.

Parameters:
TIMEOUT_CYCLES, 255, max cycles mem_req may stay high without mem_ack before the access is aborted; range 1..65535.

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_rdy  output  1  controller can accept a request
req_store  input  1  1=store, 0=load
req_funct3  input  3  RV32I load/store funct3
req_addr  input  32  byte address
req_wdata  input  32  store data, LSB-aligned
mem_req  output  1  memory access request
mem_we  output  1  memory write enable
mem_addr  output  32  word-aligned address, bits [1:0]=0
mem_wdata  output  32  write data
mem_be  output  4  byte enables
mem_ack  input  1  access complete; mem_rdata valid this cycle for reads
mem_rdata  input  32  read data
resp_valid  output  1  response present
resp_rdy  input  1  consumer accepts response
resp_data  output  32  load result after extension; 0 for stores and errors
resp_err  output  1  illegal funct3 or timeout

Behaviour:
- Reset values: req_rdy=0 during the reset cycle, then 1 in IDLE. mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, resp_valid=0, resp_data=0, resp_err=0. Timeout counter=0.
- All outputs are registered except req_rdy. req_rdy = (state==IDLE) && !rst.
- FSM states: IDLE, ACC0, ACC1, RESP.
- IDLE: on req_valid && req_rdy, latch the request. If funct3 is legal, go to ACC0 and assert mem_req on the next cycle. If funct3 is illegal, go straight to RESP with resp_err=1.
  - Legal load funct3: 0, 1, 2, 4, 5.
  - Legal store funct3: 0, 1, 2.
- Size and byte masks:
  - size = 1/2/4 bytes for funct3[1:0] = 0/1/2.
  - off = addr[1:0].
  - 8-bit mask m = ((1<<size)-1) << off.
  - lo_be = m[3:0]; hi_be = m[7:4]. split = (hi_be != 0).
- Store data: 64-bit sd = {32'b0, wdata} << (off*8). ACC0 drives sd[31:0]; ACC1 drives sd[63:32].
- ACC0: mem_addr = {addr[31:2],2'b0}, mem_be = lo_be, mem_we = store.
  - mem_req is held high, with all mem_* fields stable, until mem_ack.
  - mem_ack is ignored whenever mem_req=0.
  - On ack: load captures lo = mem_rdata. Then go to ACC1 if split, else RESP.
  - mem_req drops the cycle after ack. It re-asserts for ACC1 on the following cycle, so there is one idle cycle between the two accesses.
- ACC1: mem_addr = ACC0 address + 4, wrapping modulo 2^32 (0xFFFFFFFC+4 = 0). mem_be = hi_be. Load captures hi = mem_rdata on ack, then go to RESP.
- Timeout:
  - The counter increments each cycle mem_req=1 && !mem_ack, and clears on ack or state change.
  - When it reaches TIMEOUT_CYCLES, drop mem_req, go to RESP with resp_err=1, resp_data=0.
  - An ack arriving in the same cycle as the timeout wins; no error is flagged.
- Load result: raw = ({hi,lo} >> (off*8))[31:0], with hi=0 when not split.
  - funct3 0: sign-extend raw[7:0]. funct3 4: zero-extend raw[7:0].
  - funct3 1: sign-extend raw[15:0]. funct3 5: zero-extend raw[15:0].
  - funct3 2: raw unchanged.
- RESP: resp_valid=1, with data/err stable until resp_rdy. On resp_valid && resp_rdy, return to IDLE. resp_valid drops the next cycle; req_rdy is high that cycle.
- Latency, single access, ack in the first req cycle:
  - accept at cycle N; mem_req at N+1; ack at N+1; resp_valid at N+2.
  - Next request can be accepted at N+3 at the earliest.
- Back-pressure: while in RESP, no request is accepted and no memory access is issued.
- Reset mid-operation: rst in any state returns to IDLE next cycle with all outputs at reset values. The in-flight access is abandoned; a late mem_ack is ignored since mem_req=0.

Test Plan:
- Aligned lw at 0x100, mem_rdata=0xDEADBEEF, ack after 2 cycles -> one access: addr 0x100, be 0xF, we=0. Response 0xDEADBEEF, err=0.
- lb at 0x203, rdata=0x80xxxxxx -> be 0x8, resp 0xFFFFFF80. Same address with lbu -> resp 0x00000080.
- Misaligned lw at 0x0FE: rdata 0x3344xxxx then 0xxxxx5566 -> accesses 0x0FC be 0xC, then 0x100 be 0x3. Response 0x55663344. Also check the one idle cycle between the two accesses.
- Misaligned sh at 0xFFFFFFFF, wdata=0xABCD -> write 0xFFFFFFFC, be 0x8, wdata 0xCD000000. Then write 0x00000000, be 0x1, wdata 0x000000AB. Response err=0, data 0.
- TIMEOUT_CYCLES=4, no ack -> mem_req high exactly 4 cycles then low, resp_err=1. Also: load funct3=3 -> no mem_req, resp_err=1 one cycle after accept.
- resp_rdy held low 5 cycles, and separately rst asserted mid-ACC0 -> response held stable and req_rdy=0 throughout the stall. After the rst cycle, all outputs are at reset values and a subsequent mem_ack is ignored.
